wb_write_ctrl: RTL
==================

Name: wb_write_ctrl

Overview:
- Writer end of the 4 x 9-bit register file. Accepts execute-stage results over a valid/ready handshake and buffers them in a small FIFO.
- Drains one entry per cycle onto the register file write port (wr_en/wr_addr/wr_data).
- Bypasses pending (not-yet-committed) values onto the two read ports and publishes a per-register pending bitmap for hazard detection in decode.

Parameters:
- DATA_W, 9, register data width.
- ADDR_W, 2, register address width; NUM_REGS = 2**ADDR_W.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- res_valid  in  1  result offered.
- res_ready  out  1  FIFO can accept.
- res_addr  in  ADDR_W  destination register.
- res_data  in  DATA_W  result value.
- wb_hold  in  1  inhibit draining this cycle.
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  ADDR_W  register file write address (registered).
- wr_data  out  DATA_W  register file write data (registered).
- rd0_addr  in  ADDR_W  read port 0 address (same as driven to the register file).
- rd1_addr  in  ADDR_W  read port 1 address.
- rd0_rf_data  in  DATA_W  raw register file read data, port 0.
- rd1_rf_data  in  DATA_W  raw register file read data, port 1.
- rd0_data  out  DATA_W  bypassed read data, port 0 (combinational).
- rd1_data  out  DATA_W  bypassed read data, port 1 (combinational).
- pend  out  NUM_REGS  bit i = a write to register i is in flight.
- empty  out  1  FIFO empty and no write in flight.

Behaviour:
- Clocking/reset: one clock (clk); reset rst is synchronous, active-high. All state is updated on the rising edge.
- Reset values:
  - count = 0, head = 0, tail = 0.
  - wr_en = 0, wr_addr = 0, wr_data = 0.
  - Resulting outputs: res_ready = 1, pend = 0, empty = 1.
  - Reset mid-operation discards all buffered entries. A write asserted on wr_en in the reset cycle still reaches the register file at that edge. No further wr_en pulses occur for discarded entries.
- Push:
  - Condition: res_valid && res_ready at an edge writes {res_addr, res_data} at tail; tail++, count++.
  - res_ready = (count != DEPTH), decoded from registered count only. It has no combinational path from res_valid or the pop condition.
  - When full, a push is refused even if a pop happens in the same cycle.
- Pop:
  - Condition: count != 0 && !wb_hold at an edge loads the head entry into wr_addr/wr_data, sets wr_en = 1, then head++, count--.
  - Otherwise wr_en = 0 at that edge, and wr_addr/wr_data hold their last values.
  - Each entry produces exactly one single-cycle wr_en pulse.
- Simultaneous push and pop: allowed when 0 < count < DEPTH; count is unchanged.
  - With count = 0, a push at edge N cannot pop at edge N; the pop is evaluated on registered count.
- Pointer wrap: head/tail are log2(DEPTH) bits and wrap modulo DEPTH.
- Latency:
  - Result accepted at edge N -> wr_en high in cycle N+1 (after edge N+1) -> register file updated at edge N+2, given no hold.
  - wb_hold delays the pop by one cycle per held cycle.
- Bypass (per read port p, combinational):
  - Match sources: valid FIFO entries and the wr_* register when wr_en = 1.
  - Priority: youngest matching FIFO entry > older FIFO entries > wr_* register > rdp_rf_data.
  - A result on res_* in the current cycle is not bypassed.
- pend[i] = OR over valid FIFO entries with addr == i, OR (wr_en && wr_addr == i).
- empty = (count == 0) && !wr_en.
- Same-address writes commit in acceptance order; the last accepted value wins.

Decomposition:
- Shared package (pipeline-wide, also used by the register file and decode):
  - Constants DATA_W = 9, ADDR_W = 2, NUM_REGS = 4.
  - Typedef wb_entry_t {addr[ADDR_W], data[DATA_W]}.
- One sub-module, wb_fifo:
  - Contains storage, head/tail/count, push/pop and full/empty.
  - Exports all entry contents and a per-slot valid vector.
- Top-level: bypass match/priority, pend generation and the wr_* output register.

Test Plan:
- Reset then idle -> res_ready=1, wr_en=0, wr_addr=0, wr_data=0, pend=4'b0000, empty=1.
- Push {addr 2, data 9'h1A5} at edge N, hold low -> wr_en=1, wr_addr=2, wr_data=9'h1A5 in cycle N+1 only. pend[2]=1 from N through N+1, 0 after N+2.
- wb_hold=1, push addr1=9'h011 then addr1=9'h022 -> res_ready=0 after the 2nd push, 3rd push refused. rd0_addr=1 gives rd0_data=9'h022 with rd0_rf_data=9'h000. Release hold -> two wr_en pulses, 9'h011 then 9'h022.
- Continuous push every cycle (alternating addr 0/3), wb_hold=0 -> one wr_en per cycle, order preserved, count never exceeds 1, res_ready stays 1.
- wr_en=1 with wr_addr=3=9'h0FF, FIFO empty, rd1_addr=3, rd1_rf_data=9'h000 -> rd1_data=9'h0FF. rd0_addr=0 -> rd0_data=rd0_rf_data.
- Two entries buffered under hold, rst=1 for one cycle -> count=0, pend=0, empty=1 next cycle, and no wr_en pulses afterwards.

Source files
------------

// File: rtl/wb_write_ctrl_pkg.sv
// Pipeline-wide register file constants and the writeback entry type.
// Shared by the writeback controller, the register file and decode.
package wb_write_ctrl_pkg;

  localparam int unsigned DATA_W   = 9;
  localparam int unsigned ADDR_W   = 2;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_write_ctrl_fifo.sv
// Result FIFO for the writeback controller: storage, pointers and occupancy.
// Every slot is exported with a valid bit so the parent can bypass pending values.
module wb_fifo
  import wb_write_ctrl_pkg::*;
#(
  parameter type         entry_t = wb_entry_t,
  parameter int unsigned DEPTH   = 2,
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  entry_t                 entry_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [PTR_W-1:0]       head_o,
  output entry_t                 head_entry_o,
  output entry_t [DEPTH-1:0]     slots_o,
  output logic   [DEPTH-1:0]     valid_o
);

  entry_t [DEPTH-1:0] mem_q;
  logic   [PTR_W-1:0] head_q, head_d;
  logic   [PTR_W-1:0] tail_q, tail_d;
  logic   [CNT_W-1:0] count_q, count_d;
  logic               push_en, pop_en;

  // Occupancy flags come from registered count only, so a pop in the same
  // cycle never frees room for a push.
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_en) tail_d = tail_q + PTR_W'(1);
    if (pop_en)  head_d = head_q + PTR_W'(1);
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[tail_q] <= entry_i;
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    valid_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off        = PTR_W'(i) - head_q;
      valid_o[i] = (CNT_W'(off) < count_q);
    end
  end

  assign head_o       = head_q;
  assign head_entry_o = mem_q[head_q];
  assign slots_o      = mem_q;

endmodule

// File: rtl/wb_write_ctrl.sv
// Writeback controller: buffers execute results, drains one per cycle to the
// register file, bypasses pending values to both read ports and flags hazards.
module wb_write_ctrl
  import wb_write_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = wb_write_ctrl_pkg::DATA_W,
  parameter int unsigned ADDR_W = wb_write_ctrl_pkg::ADDR_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [ADDR_W-1:0]         res_addr,
  input  logic [DATA_W-1:0]         res_data,
  input  logic                      wb_hold,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic [ADDR_W-1:0]         rd0_addr,
  input  logic [ADDR_W-1:0]         rd1_addr,
  input  logic [DATA_W-1:0]         rd0_rf_data,
  input  logic [DATA_W-1:0]         rd1_rf_data,
  output logic [DATA_W-1:0]         rd0_data,
  output logic [DATA_W-1:0]         rd1_data,
  output logic [(1<<ADDR_W)-1:0]    pend,
  output logic                      empty
);

  localparam int unsigned NREGS = 1 << ADDR_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t               push_entry, head_entry;
  entry_t [DEPTH-1:0]   slots;
  logic   [DEPTH-1:0]   slot_valid;
  logic   [PTR_W-1:0]   head;
  logic                 fifo_full, fifo_empty, pop;

  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]    wr_data_q, wr_data_d;

  assign push_entry = '{addr: res_addr, data: res_data};
  assign pop        = !fifo_empty && !wb_hold;

  wb_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (res_valid),
    .entry_i      (push_entry),
    .pop_i        (pop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_o       (head),
    .head_entry_o (head_entry),
    .slots_o      (slots),
    .valid_o      (slot_valid)
  );

  always_comb begin
    wr_en_d   = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = head_entry.addr;
      wr_data_d = head_entry.data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Walk slots oldest to youngest from head so the youngest match wins;
  // the in-flight wr_* register sits below every FIFO entry.
  always_comb begin
    logic [PTR_W-1:0] idx;
    rd0_data = rd0_rf_data;
    rd1_data = rd1_rf_data;
    if (wr_en_q && (wr_addr_q == rd0_addr)) rd0_data = wr_data_q;
    if (wr_en_q && (wr_addr_q == rd1_addr)) rd1_data = wr_data_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (slot_valid[idx] && (slots[idx].addr == rd0_addr)) rd0_data = slots[idx].data;
      if (slot_valid[idx] && (slots[idx].addr == rd1_addr)) rd1_data = slots[idx].data;
    end
  end

  always_comb begin
    pend = '0;
    if (wr_en_q) pend[wr_addr_q] = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) pend[slots[i].addr] = 1'b1;
    end
  end

  assign res_ready = !fifo_full;
  assign empty     = fifo_empty && !wr_en_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule
